// File: rtl/div_pkg.sv
// Shared definitions for the bit-serial divisibility checker:
// FSM state encodings and the legal parameter ranges.
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int DIVISOR_MIN   = 2;
    localparam int DIVISOR_MAX   = 255;
    localparam int FRAME_LEN_MIN = 1;
    localparam int FRAME_LEN_MAX = 1024;

    function automatic bit divisor_ok(input int d);
        return (d >= DIVISOR_MIN) && (d <= DIVISOR_MAX);
    endfunction

    function automatic bit frame_len_ok(input int l);
        return (l >= FRAME_LEN_MIN) && (l <= FRAME_LEN_MAX);
    endfunction

endpackage

// File: rtl/mod_step.sv
// One bit of a serial modulo reduction: rem_next = (2*rem + bit_in) mod DIVISOR.
// Since rem < DIVISOR, 2*rem + bit_in <= 2*DIVISOR-1, so a single conditional
// subtract is enough. Purely combinational so instances can be chained for a
// multi-bit-per-cycle variant.
module mod_step
    import div_pkg::*;
#(
    parameter  int DIVISOR = 3,
    localparam int REM_W   = $clog2(DIVISOR)
) (
    input  logic [REM_W-1:0] rem,
    input  logic             bit_in,
    output logic [REM_W-1:0] rem_next
);

    localparam logic [REM_W:0] DIV_T = (REM_W+1)'(DIVISOR);

    logic [REM_W:0] t;
    logic [REM_W:0] diff;

    assign t    = {rem, bit_in};
    assign diff = t - DIV_T;

    // Reduce the doubled-plus-bit value back into [0, DIVISOR).
    always_comb begin
        rem_next = t[REM_W-1:0];
        if (t >= DIV_T) begin
            rem_next = diff[REM_W-1:0];
        end
    end

endmodule

// File: rtl/serial_divisible_by_n.sv
// Bit-serial divisibility checker. Accepts FRAME_LEN bits MSB-first, one per
// qualified clock, keeps a running remainder modulo DIVISOR and reports whether
// the completed frame was divisible. Cost is independent of FRAME_LEN apart
// from the bit counter.
module serial_divisible_by_n
    import div_pkg::*;
#(
    parameter  int DIVISOR   = 3,
    parameter  int FRAME_LEN = 8,
    localparam int REM_W     = $clog2(DIVISOR),
    localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             bit_valid_i,
    input  logic             bit_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] bit_cnt_o,
    output logic [REM_W-1:0] rem_o,
    output logic             done_o,
    output logic             divisible_o
);

    // Refuse to elaborate with parameters outside the supported range.
    generate
        if (!divisor_ok(DIVISOR)) begin : g_bad_divisor
            $error("serial_divisible_by_n: DIVISOR must be in 2..255");
        end
        if (!frame_len_ok(FRAME_LEN)) begin : g_bad_frame_len
            $error("serial_divisible_by_n: FRAME_LEN must be in 1..1024");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic             div_q, div_d;
    logic [REM_W-1:0] rem_step;

    mod_step #(
        .DIVISOR (DIVISOR)
    ) u_mod_step (
        .rem      (rem_q),
        .bit_in   (bit_i),
        .rem_next (rem_step)
    );

    // State and all output registers; reset clears everything immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            div_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            div_q   <= div_d;
        end
    end

    // Next-state logic. start_i has priority in every state: it discards any
    // same-cycle bit and, in DONE, suppresses the done pulse of that frame.
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        div_d   = div_q;

        if (start_i) begin
            state_d = ST_SHIFT;
            busy_d  = 1'b1;
            cnt_d   = '0;
            rem_d   = '0;
            div_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // bits are ignored until a frame is started
                end
                ST_SHIFT: begin
                    if (bit_valid_i) begin
                        rem_d = rem_step;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_CNT) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    done_d  = 1'b1;
                    div_d   = (rem_q == '0);
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign bit_cnt_o   = cnt_q;
    assign rem_o       = rem_q;
    assign done_o      = done_q;
    assign divisible_o = div_q;

endmodule

// File: tb/tb_serial_divisible_by_n.sv
// Bench for serial_divisible_by_n: three instances (3/4, 7/8, 5/16) checked
// every cycle against an arithmetic model, plus directed literal expectations.
module tb_serial_divisible_by_n;

    logic clk = 1'b0;
    logic rst;
    logic [2:0] start, bv, bin;
    logic [2:0] o_busy, o_done, o_div;
    logic [2:0] cnt0; logic [1:0] rem0;
    logic [3:0] cnt1; logic [2:0] rem1;
    logic [4:0] cnt2; logic [2:0] rem2;

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen [3];

    always #5 clk = ~clk;

    serial_divisible_by_n #(.DIVISOR(3), .FRAME_LEN(4)) u_d0 (
        .clk_i(clk), .rst_i(rst), .start_i(start[0]), .bit_valid_i(bv[0]), .bit_i(bin[0]),
        .busy_o(o_busy[0]), .bit_cnt_o(cnt0), .rem_o(rem0), .done_o(o_done[0]), .divisible_o(o_div[0]));
    serial_divisible_by_n #(.DIVISOR(7), .FRAME_LEN(8)) u_d1 (
        .clk_i(clk), .rst_i(rst), .start_i(start[1]), .bit_valid_i(bv[1]), .bit_i(bin[1]),
        .busy_o(o_busy[1]), .bit_cnt_o(cnt1), .rem_o(rem1), .done_o(o_done[1]), .divisible_o(o_div[1]));
    serial_divisible_by_n #(.DIVISOR(5), .FRAME_LEN(16)) u_d2 (
        .clk_i(clk), .rst_i(rst), .start_i(start[2]), .bit_valid_i(bv[2]), .bit_i(bin[2]),
        .busy_o(o_busy[2]), .bit_cnt_o(cnt2), .rem_o(rem2), .done_o(o_done[2]), .divisible_o(o_div[2]));

    function automatic longint divn(input int i);
        case (i) 0: return 3; 1: return 7; default: return 5; endcase
    endfunction

    function automatic int flen(input int i);
        case (i) 0: return 4; 1: return 8; default: return 16; endcase
    endfunction

    function automatic longint get_cnt(input int i);
        case (i) 0: return longint'(cnt0); 1: return longint'(cnt1); default: return longint'(cnt2); endcase
    endfunction

    function automatic longint get_rem(input int i);
        case (i) 0: return longint'(rem0); 1: return longint'(rem1); default: return longint'(rem2); endcase
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- model: frame value as a plain integer ----------------
    typedef struct {
        longint val;
        int     cnt;
        bit     in_frame;
        bit     finishing;
        bit     busy;
        bit     done;
        bit     div;
    } model_t;

    model_t mdl [3];

    function automatic model_t step(input model_t m, input int i, input logic s, input logic v, input logic b);
        model_t n = m;
        n.done = 1'b0;
        if (s) begin
            n = '{default: 0};
            n.in_frame = 1'b1;
            n.busy     = 1'b1;
        end else if (m.finishing) begin
            n.finishing = 1'b0;
            n.done      = 1'b1;
            n.div       = (m.val % divn(i)) == 0;
            n.busy      = 1'b0;
        end else if (m.in_frame && v) begin
            n.val = m.val * 2 + longint'(b);
            n.cnt = m.cnt + 1;
            if (n.cnt == flen(i)) begin
                n.in_frame  = 1'b0;
                n.finishing = 1'b1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) mdl[i] <= '{default: 0};
            else     mdl[i] <= step(mdl[i], i, start[i], bv[i], bin[i]);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("busy%0d", i), longint'(o_busy[i]), longint'(mdl[i].busy));
            chk($sformatf("cnt%0d", i),  get_cnt(i),          longint'(mdl[i].cnt));
            chk($sformatf("rem%0d", i),  get_rem(i),          mdl[i].val % divn(i));
            chk($sformatf("done%0d", i), longint'(o_done[i]), longint'(mdl[i].done));
            chk($sformatf("div%0d", i),  longint'(o_div[i]),  longint'(mdl[i].div));
            done_seen[i] <= done_seen[i] + int'(o_done[i]);
        end
        chk("rem2_below_5", longint'(rem2 < 3'd5), 1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int i, input logic with_bit, input logic b);
        start[i] = 1'b1; bv[i] = with_bit; bin[i] = b;
        tick();
        start[i] = 1'b0; bv[i] = 1'b0;
    endtask

    task automatic send_bits(input int i, input longint v, input int n, input int gap_max);
        for (int k = n - 1; k >= 0; k--) begin
            repeat ($urandom_range(gap_max, 0)) tick();
            bv[i] = 1'b1; bin[i] = v[k];
            tick();
            bv[i] = 1'b0;
        end
    endtask

    initial begin
        int d0;
        int d1;
        rst = 1'b1; start = '0; bv = '0; bin = '0;
        for (int i = 0; i < 3; i++) done_seen[i] = 0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // reset state
        chk("rst_busy0", longint'(o_busy[0]), 0);
        chk("rst_cnt0",  longint'(cnt0), 0);
        chk("rst_rem0",  longint'(rem0), 0);
        chk("rst_done0", longint'(o_done[0]), 0);
        chk("rst_div0",  longint'(o_div[0]), 0);

        // exhaustive 4-bit frames, divisor 3; done appears FRAME_LEN+2 cycles on
        for (int v = 0; v < 16; v++) begin
            d0 = done_seen[0];
            start_frame(0, 1'b0, 1'b0);
            send_bits(0, longint'(v), 4, 0);
            chk("ex_done_early", longint'(o_done[0]), 0);
            chk("ex_busy_in_done", longint'(o_busy[0]), 1);
            tick();
            chk("ex_done", longint'(o_done[0]), 1);
            chk("ex_div",  longint'(o_div[0]), longint'((v % 3) == 0));
            chk("ex_cnt",  longint'(cnt0), 4);
            chk("ex_busy_after", longint'(o_busy[0]), 0);
            tick();
            chk("ex_done_one_cycle", longint'(o_done[0]), 0);
            chk("ex_done_count", longint'(done_seen[0] - d0), 1);
        end

        // divisor 7 with random valid gaps
        start_frame(1, 1'b0, 1'b0);
        send_bits(1, 147, 8, 3);
        tick();
        chk("d7_147_done", longint'(o_done[1]), 1);
        chk("d7_147_div",  longint'(o_div[1]), 1);
        chk("d7_147_rem",  longint'(rem1), 0);
        start_frame(1, 1'b0, 1'b0);
        send_bits(1, 148, 8, 3);
        tick();
        chk("d7_148_div", longint'(o_div[1]), 0);
        chk("d7_148_rem", longint'(rem1), 1);

        // divisor 5, 16-bit all-ones
        start_frame(2, 1'b0, 1'b0);
        send_bits(2, 'hFFFF, 16, 1);
        tick();
        chk("d5_ffff_rem", longint'(rem2), 0);
        chk("d5_ffff_div", longint'(o_div[2]), 1);
        chk("d5_ffff_cnt", longint'(cnt2), 16);

        // abort after 3 bits, then a full frame of 9
        d0 = done_seen[0];
        start_frame(0, 1'b0, 1'b0);
        send_bits(0, 5, 3, 0);
        start_frame(0, 1'b0, 1'b0);
        send_bits(0, 9, 4, 0);
        tick();
        chk("abort_done", longint'(o_done[0]), 1);
        chk("abort_div",  longint'(o_div[0]), 1);
        chk("abort_cnt",  longint'(cnt0), 4);
        tick();
        chk("abort_single_done", longint'(done_seen[0] - d0), 1);

        // reset mid-frame, after 2 bits
        start_frame(1, 1'b0, 1'b0);
        send_bits(1, 3, 2, 0);
        chk("mid_cnt_before_rst", longint'(cnt1), 2);
        d1 = done_seen[1];
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", longint'(o_busy[1]), 0);
        chk("mid_rst_cnt",  longint'(cnt1), 0);
        chk("mid_rst_rem",  longint'(rem1), 0);
        chk("mid_rst_done", longint'(o_done[1]), 0);
        chk("mid_rst_div",  longint'(o_div[1]), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        bv[1] = 1'b1; bin[1] = 1'b1;
        repeat (10) tick();
        bv[1] = 1'b0;
        chk("post_rst_busy", longint'(o_busy[1]), 0);
        chk("post_rst_cnt",  longint'(cnt1), 0);
        chk("post_rst_no_done", longint'(done_seen[1] - d1), 0);

        // start together with a bit while idle
        start_frame(0, 1'b1, 1'b1);
        chk("idle_sim_cnt",  longint'(cnt0), 0);
        chk("idle_sim_rem",  longint'(rem0), 0);
        chk("idle_sim_busy", longint'(o_busy[0]), 1);
        send_bits(0, 6, 4, 0);
        tick();
        chk("idle_sim_done", longint'(o_done[0]), 1);
        chk("idle_sim_div",  longint'(o_div[0]), 1);

        // start together with a bit while in DONE: that frame's pulse is dropped
        tick();
        d0 = done_seen[0];
        start_frame(0, 1'b0, 1'b0);
        send_bits(0, 4, 4, 0);
        start_frame(0, 1'b1, 1'b1);
        chk("done_sim_done", longint'(o_done[0]), 0);
        chk("done_sim_cnt",  longint'(cnt0), 0);
        chk("done_sim_busy", longint'(o_busy[0]), 1);
        send_bits(0, 9, 4, 0);
        tick();
        chk("done_sim_final_done", longint'(o_done[0]), 1);
        chk("done_sim_final_div",  longint'(o_div[0]), 1);
        tick();
        chk("done_sim_pulses", longint'(done_seen[0] - d0), 1);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
